// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter with burst limit
// Define DMEM_ARB_CPU_PRIO_EN to give port 0 fixed priority instead of round-robin.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BCNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            r_state;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_last;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_limit;
    logic w_force0;
    logic w_force1;
    logic w_pick1;

    assign w_gnt0  = (r_state == OWN0) & req0;
    assign w_gnt1  = (r_state == OWN1) & req1;
    assign w_limit = (r_bcnt >= BCNT_LAST);

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign w_force0 = 1'b0;
    assign w_force1 = 1'b1;
    assign w_pick1  = 1'b0;
`else
    assign w_force0 = w_limit;
    assign w_force1 = w_limit;
    assign w_pick1  = ~r_last;
`endif

    // The burst counter saturates so a long uncontended burst still hands over
    // on the first contended transfer past the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_bcnt    <= '0;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            case (r_state)
                IDLE: begin
                    r_bcnt <= '0;
                    if (req0 && !(req1 && w_pick1)) begin
                        r_state <= OWN0;
                        r_last  <= 1'b0;
                    end else if (req1) begin
                        r_state <= OWN1;
                        r_last  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!req0 || (req1 && w_force0)) begin
                        r_bcnt <= '0;
                        if (req1) begin
                            r_state <= OWN1;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!w_limit) begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                OWN1: begin
                    if (!req1 || (req0 && w_force1)) begin
                        r_bcnt <= '0;
                        if (req0) begin
                            r_state <= OWN0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (!w_limit) begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_bcnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == OWN0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (r_state == OWN1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign mem_en  = w_gnt0 | w_gnt1;
    assign mem_we  = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_CPU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, a + 8'd3};
    endfunction

    // Memory environment: synchronous read, one-cycle latency.
    bit [31:0] mem [256];
    bit        mem_wr [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]]    <= mem_wdata;
                mem_wr[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= mem_wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner as an int (-1 = none), transfers taken this tenure.
    int          m_owner, m_cnt, m_last, m_g;
    bit          m_rv0, m_rv1;
    logic [31:0] m_rdata;
    bit [31:0]   ref_mem [256];
    bit          ref_wr [256];
    logic        s_gnt0, s_gnt1, s_rv0, s_rv1, s_we;
    logic [31:0] s_rdata;

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0; m_g = -1;
    endtask

    task automatic tick();
        bit          rq [2];
        bit          w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        int          g, nxt, o;
        rq[0] = req0; rq[1] = req1; w[0] = we0; w[1] = we1;
        a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
        #1;
        s_gnt0 = gnt0; s_gnt1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1;
        s_rdata = rdata; s_we = mem_we;
        g = (m_owner >= 0 && rq[m_owner]) ? m_owner : -1;
        chk1("gnt0", gnt0, g == 0);
        chk1("gnt1", gnt1, g == 1);
        chk1("mem_en", mem_en, g >= 0);
        chk1("mem_we", mem_we, (g >= 0) ? w[g] : 1'b0);
        chk32("mem_addr", mem_addr, (m_owner >= 0) ? a[m_owner] : 32'h0);
        chk32("mem_wdata", mem_wdata, (m_owner >= 0) ? d[m_owner] : 32'h0);
        chk1("rvalid0", rvalid0, m_rv0);
        chk1("rvalid1", rvalid1, m_rv1);
        if (m_rv0 || m_rv1) chk32("rdata", rdata, m_rdata);
        m_g = g;
        m_rv0 = (g == 0) && !w[0];
        m_rv1 = (g == 1) && !w[1];
        if (g >= 0) begin
            if (w[g]) begin
                ref_mem[a[g][7:0]] = d[g];
                ref_wr[a[g][7:0]]  = 1'b1;
            end else begin
                m_rdata = ref_wr[a[g][7:0]] ? ref_mem[a[g][7:0]] : init_word(a[g][7:0]);
            end
            m_cnt++;
        end
        if (m_owner < 0) begin
            if (rq[0] && rq[1]) nxt = PRIO ? 0 : 1 - m_last;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else begin
            o = m_owner;
            if (!rq[o])
                nxt = rq[1-o] ? 1 - o : -1;
            else if (rq[1-o] && (PRIO ? (o == 1) : (m_cnt >= MAX_BURST)))
                nxt = 1 - o;
            else
                nxt = o;
        end
        if (nxt != m_owner) begin
            m_cnt = 0;
            if (nxt >= 0) m_last = nxt;
        end
        m_owner = nxt;
        @(negedge clk);
    endtask

    typedef struct {
        bit r0;
        bit r1;
        bit g0;
        bit g1;
    } vec_t;
    vec_t tv [$];

    task automatic add(bit r0, bit r1, bit g0, bit g1, int n);
        for (int k = 0; k < n; k++) tv.push_back('{r0, r1, g0, g1});
    endtask

    bit p0, p1;

    initial begin
        if (PRIO) begin
            add(1, 1, 0, 0, 1);
            add(1, 1, 1, 0, 20);
            add(0, 1, 0, 0, 1);
            add(0, 1, 0, 1, 1);
            add(1, 1, 0, 1, 1);
            add(1, 1, 1, 0, 1);
            add(0, 0, 0, 0, 2);
        end else begin
            add(1, 1, 0, 0, 1);
            add(1, 1, 1, 0, 4);
            add(1, 1, 0, 1, 4);
            add(1, 1, 1, 0, 1);
            add(0, 1, 0, 0, 1);
            add(1, 1, 0, 1, 2);
            add(1, 0, 0, 0, 1);
            add(1, 0, 1, 0, 1);
            add(1, 1, 1, 0, 3);
            add(1, 1, 0, 1, 1);
            add(0, 0, 0, 0, 2);
        end

        // Reset held with both ports requesting.
        req0 = 1; req1 = 1;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        reset = 1;
        model_reset();

        for (int i = 0; i < tv.size(); i++) begin
            req0 = tv[i].r0; req1 = tv[i].r1; we0 = 0; we1 = 0;
            addr0 = {24'h0, 8'($urandom)}; addr1 = {24'h0, 8'($urandom)};
            tick();
            chk1($sformatf("tbl%0d_gnt0", i), s_gnt0, tv[i].g0);
            chk1($sformatf("tbl%0d_gnt1", i), s_gnt1, tv[i].g1);
        end

        // Single read from port 0.
        req1 = 0; req0 = 1; we0 = 0; addr0 = 32'h10;
        tick();
        tick();
        chk1("rd_gnt0", s_gnt0, 1'b1);
        req0 = 0;
        tick();
        chk1("rd_rvalid0", s_rv0, 1'b1);
        chk32("rd_rdata", s_rdata, 32'hDEADBEEF);
        chk1("rd_rvalid1", s_rv1, 1'b0);

        // Write then read the same address back to back.
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55;
        tick();
        tick();
        chk1("wr_gnt0", s_gnt0, 1'b1);
        chk1("wr_mem_we", s_we, 1'b1);
        we0 = 0;
        tick();
        chk1("rb_gnt0", s_gnt0, 1'b1);
        chk1("rb_mem_we", s_we, 1'b0);
        req0 = 0;
        tick();
        chk1("rb_rvalid0", s_rv0, 1'b1);
        chk32("rb_rdata", s_rdata, 32'h55);

        // Reset with a read outstanding drops the response.
        req0 = 1; we0 = 0; addr0 = 32'h30;
        tick();
        #1;
        chk1("rr_gnt0", gnt0, 1'b1);
        #2;
        reset = 0; req0 = 0;
        @(negedge clk);
        #1;
        chk1("rr_rvalid0", rvalid0, 1'b0);
        chk1("rr_gnt0_after", gnt0, 1'b0);
        reset = 1;
        model_reset();
        @(negedge clk);

        // Random traffic; a pending request holds its command until granted.
        p0 = 0; p1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!p0) begin
                req0 = ($urandom_range(0, 3) != 0); we0 = $urandom_range(0, 1) == 1;
                addr0 = {24'h0, 8'($urandom)}; wdata0 = $urandom;
            end
            if (!p1) begin
                req1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1) == 1;
                addr1 = {24'h0, 8'($urandom)}; wdata1 = $urandom;
            end
            tick();
            p0 = req0 && (m_g != 0);
            p1 = req1 && (m_g != 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
